// File: rtl/ram_master.sv
// ram_master: single-word read/write initiator for the 4Kx4 async RAM; req accepted only while ready, otherwise ignored.
// Latency to done: W+2 cycles, or 2W+4 for writes when RAM_MASTER_WRITE_VERIFY_EN is defined (write read-back check).
module ram_master #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [11:0] addr,
   input  logic [3:0]  wdata,
   output logic        ready,
   output logic        done,
   output logic [3:0]  rdata,
   output logic        verify_err,
   output logic [11:0] address_ram,
   output logic        csRAM,
   output logic        weRAM,
   inout  wire  [3:0]  data
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      RELEASE
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      ,
      TURN,
      VERIFY,
      VEND
`endif
   } state_t;

   state_t      state, nxt;
   logic [3:0]  cnt;
   logic        we_q;
   logic [3:0]  wdata_q;
   logic        drive;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
   logic        verr_q;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req) nxt = SETUP;
         SETUP:   nxt = ACCESS;
         ACCESS:  if (cnt == 4'd0) nxt = RELEASE;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
         RELEASE: nxt = we_q ? TURN : IDLE;
         TURN:    nxt = VERIFY;
         VERIFY:  if (cnt == 4'd0) nxt = VEND;
         VEND:    nxt = IDLE;
`else
         RELEASE: nxt = IDLE;
`endif
         default: nxt = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
`ifdef RAM_MASTER_WRITE_VERIFY_EN
   assign done       = ((state == RELEASE) && !we_q) || (state == VEND);
   assign verify_err = (state == VEND) && verr_q;
`else
   assign done       = (state == RELEASE);
   assign verify_err = 1'b0;
`endif

   // Bus only driven for writes, from setup through release (hold time).
   assign data = drive ? wdata_q : 4'bzzzz;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         we_q        <= 1'b0;
         wdata_q     <= 4'd0;
         address_ram <= 12'd0;
         csRAM       <= 1'b0;
         weRAM       <= 1'b0;
         drive       <= 1'b0;
         rdata       <= 4'd0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
         verr_q      <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (state == IDLE && req) begin
            we_q        <= we;
            wdata_q     <= wdata;
            address_ram <= addr;
         end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
         if (state == SETUP || state == TURN)
            cnt <= CNT_INIT;
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
         csRAM <= (nxt == ACCESS) || (nxt == VERIFY);
         if (state == VERIFY && cnt == 4'd0)
            verr_q <= (data != wdata_q);
`else
         if (state == SETUP)
            cnt <= CNT_INIT;
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
         csRAM <= (nxt == ACCESS);
`endif
         // Strobes are decoded from the next state so they leave the flops glitch-free.
         weRAM <= (nxt == ACCESS) && we_q;
         drive <= ((nxt == SETUP) && we) || (((nxt == ACCESS) || (nxt == RELEASE)) && we_q);
         if (state == ACCESS && cnt == 4'd0 && !we_q)
            rdata <= data;
      end
   end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: instance 0 uses W=1, instance 1 uses W=3, each with its own async RAM model.
module tb_ram_master;

`ifdef RAM_MASTER_WRITE_VERIFY_EN
   localparam bit VEN = 1'b1;
`else
   localparam bit VEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req   [2];
   logic        we    [2];
   logic [11:0] addr  [2];
   logic [3:0]  wdata [2];
   logic        rdy   [2];
   logic        done  [2];
   logic        verr  [2];
   logic        cs    [2];
   logic        wer   [2];
   logic [3:0]  rdata [2];
   logic [11:0] aram  [2];
   wire  [3:0]  data0, data1;
   logic        corrupt;
   logic [3:0]  mem0 [4096];
   logic [3:0]  mem1 [4096];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_master #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .ready(rdy[0]), .done(done[0]), .rdata(rdata[0]), .verify_err(verr[0]),
      .address_ram(aram[0]), .csRAM(cs[0]), .weRAM(wer[0]), .data(data0));

   ram_master #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .ready(rdy[1]), .done(done[1]), .rdata(rdata[1]), .verify_err(verr[1]),
      .address_ram(aram[1]), .csRAM(cs[1]), .weRAM(wer[1]), .data(data1));

   // Asynchronous RAM models: drive on read strobe, store while write strobe is high.
   assign data0 = (cs[0] && !wer[0]) ? mem0[aram[0]] : 4'bzzzz;
   assign data1 = (cs[1] && !wer[1]) ? (corrupt ? 4'h7 : mem1[aram[1]]) : 4'bzzzz;

   always @(posedge clk) begin
      if (cs[0] && wer[0]) mem0[aram[0]] <= data0;
      if (cs[1] && wer[1]) mem1[aram[1]] <= data1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access on instance d, starting at the falling edge of an idle cycle.
   task automatic access(input int d, input bit w, input logic [11:0] a, input logic [3:0] wd,
                         input logic [3:0] exp_rd, input bit exp_verr, input string tag);
      int wc, cs_n, we_n, first_cs, done_k, bad, exp_done, exp_cs;
      wc = (d == 0) ? 1 : 3;
      cs_n = 0; we_n = 0; first_cs = 0; done_k = 0; bad = 0;
      exp_done = (w && VEN) ? 2 * wc + 4 : wc + 2;
      exp_cs   = (w && VEN) ? 2 * wc : wc;
      chk({tag, "_ready_before"}, 16'(rdy[d]), 16'd1);
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      for (int k = 1; k <= 40 && done_k == 0; k++) begin
         @(negedge clk);
         req[d] = 1'b0;
         if (k == 1) chk({tag, "_addr_setup"}, 16'(aram[d]), 16'(a));
         if (cs[d]) begin
            cs_n++;
            if (first_cs == 0) first_cs = k;
         end
         if (wer[d]) we_n++;
         if (wer[d] && !cs[d]) bad++;
         if (verr[d] && !done[d]) bad++;
         if (rdy[d]) bad++;
         if (done[d]) done_k = k;
      end
      chk({tag, "_done_cycle"}, 16'(done_k), 16'(exp_done));
      chk({tag, "_cs_cycles"}, 16'(cs_n), 16'(exp_cs));
      chk({tag, "_we_cycles"}, 16'(we_n), w ? 16'(wc) : 16'd0);
      chk({tag, "_first_cs"}, 16'(first_cs), 16'd2);
      chk({tag, "_bus_rules"}, 16'(bad), 16'd0);
      if (!w) chk({tag, "_rdata"}, 16'(rdata[d]), 16'(exp_rd));
      chk({tag, "_verify_err"}, 16'(verr[d]), 16'(exp_verr));
      @(negedge clk);
      chk({tag, "_ready_after"}, 16'(rdy[d]), 16'd1);
      chk({tag, "_done_after"}, 16'(done[d]), 16'd0);
   endtask

   initial begin
      int ready_n, done_n, bad;

      // Reset held 3 cycles with a pending request.
      reset = 1'b0; corrupt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b1; we[i] = 1'b1; addr[i] = 12'h123; wdata[i] = 4'hA;
      end
      repeat (3) @(negedge clk);
      chk("rst_cs0", 16'(cs[0]), 16'd0);
      chk("rst_we0", 16'(wer[0]), 16'd0);
      chk("rst_ready0", 16'(rdy[0]), 16'd1);
      chk("rst_done0", 16'(done[0]), 16'd0);
      chk("rst_rdata0", 16'(rdata[0]), 16'd0);
      chk("rst_addr0", 16'(aram[0]), 16'd0);
      chk("rst_cs1", 16'(cs[1]), 16'd0);
      chk("rst_ready1", 16'(rdy[1]), 16'd1);
      chk("rst_verr1", 16'(verr[1]), 16'd0);
      reset = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);

      // W=1: read-back uses a different wdata so a driving master would corrupt rdata.
      access(0, 1'b1, 12'h123, 4'hA, 4'h0, 1'b0, "w1_wr123");
      access(0, 1'b1, 12'h200, 4'h3, 4'h0, 1'b0, "w1_wr200");
      access(0, 1'b0, 12'h123, 4'h0, 4'hA, 1'b0, "w1_rd123");

      // W=3 boundary addresses.
      access(1, 1'b1, 12'hFFF, 4'h5, 4'h0, 1'b0, "w3_wrFFF");
      access(1, 1'b1, 12'h000, 4'h9, 4'h0, 1'b0, "w3_wr000");
      access(1, 1'b0, 12'hFFF, 4'h0, 4'h5, 1'b0, "w3_rdFFF");
      access(1, 1'b0, 12'h000, 4'h0, 4'h9, 1'b0, "w3_rd000");

      // Back-to-back reads with req held: one access every 4 cycles at W=1.
      ready_n = 0; done_n = 0; bad = 0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 12'h123;
      for (int i = 0; i < 20; i++) begin
         if (rdy[0]) begin
            ready_n++;
            if (i % 4 != 0) bad++;
         end
         if (done[0]) begin
            done_n++;
            if (i % 4 != 3) bad++;
         end
         @(negedge clk);
      end
      req[0] = 1'b0;
      chk("b2b_ready_cnt", 16'(ready_n), 16'd5);
      chk("b2b_done_cnt", 16'(done_n), 16'd5);
      chk("b2b_phase", 16'(bad), 16'd0);
      chk("b2b_rdata", 16'(rdata[0]), 16'hA);
      @(negedge clk);

      // Reset during the write strobe of the W=3 instance.
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 12'h050; wdata[1] = 4'h2;
      @(negedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      chk("mid_cs_active", 16'(cs[1]), 16'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_cs_drop", 16'(cs[1]), 16'd0);
      chk("mid_we_drop", 16'(wer[1]), 16'd0);
      chk("mid_ready", 16'(rdy[1]), 16'd1);
      reset = 1'b1;
      done_n = (done[1] == 1'b1) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done[1]) done_n++;
      end
      chk("mid_no_done", 16'(done_n), 16'd0);
      access(1, 1'b0, 12'hFFF, 4'h0, 4'h5, 1'b0, "mid_rdFFF");

`ifdef RAM_MASTER_WRITE_VERIFY_EN
      access(0, 1'b1, 12'h010, 4'h6, 4'h0, 1'b0, "vfy_ok");
      corrupt = 1'b1;
      access(1, 1'b1, 12'h010, 4'h6, 4'h0, 1'b1, "vfy_bad");
      corrupt = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_master.md
# ram_master

Bus initiator for the 4 K × 4 asynchronous RAM port: it accepts single-word read/write requests from the datapath and generates the `address_ram`, `csRAM` and `weRAM` strobes. It owns the bidirectional 4-bit `data` bus whenever the RAM is not driving it. It sits between the processor's memory-access logic and the RAM instance, and serialises every access into a glitch-free setup/strobe/release sequence.

## Interface
- `WAIT_CYCLES`, default 1: number of cycles `csRAM` stays high per strobe; legal range 1–15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low.
- `req` input 1: access request; sampled only while `ready`=1.
- `we` input 1: 1 = write, 0 = read; captured with `req`.
- `addr` input 12: word address; captured with `req`.
- `wdata` input 4: write data; captured with `req`.
- `ready` output 1: 1 only in IDLE.
- `done` output 1: one-cycle pulse at the end of each access.
- `rdata` output 4: read result; valid from `done` until the next read completes.
- `verify_err` output 1: write-verify mismatch flag; valid with `done`.
- `address_ram` output 12: RAM address.
- `csRAM` output 1: RAM chip select.
- `weRAM` output 1: RAM write enable.
- `data` inout 4: RAM data bus, driven only as specified below, otherwise `4'bzzzz`.

## Operation
- States: IDLE, SETUP, ACCESS, RELEASE, TURN, VERIFY, VEND. TURN, VERIFY and VEND exist only with the macro defined.
- All RAM-side outputs are registered.
- **IDLE:** `csRAM`=0, `weRAM`=0, `data` hi-Z, `ready`=1.
  - `req`=1 captures `we`, `addr` and `wdata`, then → SETUP.
  - `req` while not in IDLE is ignored, not queued.
- **SETUP:** `address_ram`=addr, `csRAM`=0, `weRAM`=0.
  - Write: `data` driven with wdata.
  - Read: `data` hi-Z.
  - Always → ACCESS.
- **ACCESS:** `csRAM`=1, `weRAM`=we, held for WAIT_CYCLES cycles by a down-counter; address unchanged.
  - Write: `data` remains driven.
  - Read: `data` hi-Z. `rdata` is loaded from `data` at the edge that ends the last ACCESS cycle.
  - → RELEASE.
- **RELEASE:** `csRAM`=0 and `weRAM`=0 fall together.
  - Write: `data` still driven (hold time).
  - `done`=1 unless a write with verify enabled.
  - → IDLE, or → TURN for a verified write.
- **TURN:** all strobes 0, `data` hi-Z; this is the bus turnaround cycle. → VERIFY.
- **VERIFY:** `csRAM`=1, `weRAM`=0, `data` hi-Z for WAIT_CYCLES cycles. The bus is compared against captured wdata at the last edge. → VEND.
- **VEND:** strobes 0, `done`=1, `verify_err`=(mismatch). → IDLE.
- Bus rules:
  - The master never drives `data` while `csRAM`=1 and `weRAM`=0.
  - `weRAM`=1 only when `csRAM`=1.
  - Address and data are stable one full cycle before `csRAM` rises.
- Address is used as-is; there is no increment and no wrap logic.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `ready`=1, `done`=0, `csRAM`=0, `weRAM`=0, `data` hi-Z, `address_ram`=0, `rdata`=0, `verify_err`=0, wait counter 0.
- Reset mid-access aborts at that edge: strobes drop immediately and no `done` is issued. A write that was interrupted may or may not have completed.
- Cycle numbering: E0 is the edge that accepts `req`, and cycle k follows edge Ek.
  - SETUP = cycle 1.
  - ACCESS = cycles 2..W+1 (W = WAIT_CYCLES).
  - RELEASE = cycle W+2: `done` for reads and unverified writes.
  - Verified write: TURN = W+3, VERIFY = W+4..2W+3, VEND = 2W+4 (`done`).
- `ready` returns to 1 in the cycle after `done`. A `req` held high throughout is accepted at that cycle's closing edge. Minimum request spacing is W+3 cycles (plain) or 2W+5 cycles (verified write).
- `verify_err` is 0 in every cycle other than VEND.

## Configuration
- Macro `RAM_MASTER_WRITE_VERIFY_EN`.
- Defined: every write is followed by TURN/VERIFY/VEND, and `verify_err` reports whether the read-back differs from wdata.
- Undefined:
  - Writes end in RELEASE with `done`.
  - `verify_err` is tied to 0.
  - The TURN, VERIFY and VEND states are not built.
- Reads behave identically in both builds.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles while `req`=1 → `csRAM`=0, `weRAM`=0, `data`=z, `ready`=1, `rdata`=0, no `done`.
- **Write then read, W=1:**
  - Write 0xA to 0x123 → `csRAM`=1 with `weRAM`=1 in cycle 2 only, `done` in cycle 3.
  - Read 0x123 → `rdata`=0xA with `done` in cycle 3; the master never drives `data` during the strobe.
- **Boundary addresses, W=3:**
  - Write 0x5 to 0xFFF and 0x9 to 0x000, then read both → 0x5 and 0x9.
  - `csRAM` is high exactly 3 cycles per access; `done` arrives in cycle 5.
- **Back-to-back requests:** `req` held high for 20 cycles → one access per W+3 cycles; `ready` is 0 throughout each access.
- **Reset mid-write:** assert `reset`=0 during ACCESS → `csRAM`=0 next cycle, no `done`, then a new read is accepted normally.
- **Write-verify (macro defined):**
  - Write 0x6 to 0x010 → TURN cycle with `data`=z, `done` in cycle 2W+4 with `verify_err`=0.
  - Force the RAM model to return 0x7 → `verify_err`=1.
